// File: rtl/tiny16_intc_pkg.sv
// tiny16_intc_pkg
// Shared definitions for the tiny16 interrupt controller.
//   regOffset_e  : word offsets inside the 4-word register window
//   SYNC_DEPTH   : number of synchroniser flops per request line
//   DATA_WIDTH   : width of the core data bus
package tiny16_intc_pkg;

    typedef enum logic [1:0] {
        REG_PENDING = 2'd0,
        REG_ENABLE  = 2'd1,
        REG_ACTIVE  = 2'd2,
        REG_MODE    = 2'd3
    } regOffset_e;

    localparam int SYNC_DEPTH = 2;
    localparam int DATA_WIDTH = 16;

endpackage

// File: rtl/tiny16_intc_prio.sv
// tiny16_intc_prio
// Combinational priority encoder: the lowest-numbered set request wins and
// is reported as index+1, so a vector of 0 means "no request".
//   request_i : pending & enable, one bit per source
//   vector_o  : encoded vector handed to the core
module tiny16_intc_prio
    import tiny16_intc_pkg::*;
#(
    parameter int SOURCES        = 8,
    parameter int INTERRUPT_BITS = 4
) (
    input  logic [SOURCES-1:0]        request_i,
    output logic [INTERRUPT_BITS-1:0] vector_o
);

    // Scanning from the top down lets the lowest set bit overwrite any
    // higher one, giving lowest-index priority without a found flag.
    always_comb begin
        vector_o = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (request_i[i]) begin
                vector_o = INTERRUPT_BITS'(i + 1);
            end
        end
    end

endmodule

// File: rtl/tiny16_intc.sv
// tiny16_intc
// Memory-mapped interrupt controller for the tiny16 core. Request lines are
// synchronised, edge-detected into PENDING, masked by ENABLE and encoded
// into a nonzero vector that the core uses directly as the ISR address.
// Register window (4 words at BASE_ADDRESS):
//   +0 PENDING  read, write-1-to-clear
//   +1 ENABLE   read/write
//   +2 ACTIVE   read-only, last vector sampled by the core
//   +3 MODE     level-sensitive select when INTC_LEVEL_EN is defined,
//               otherwise reads 0 and ignores writes
// Ports:
//   clk, nreset   : clock, synchronous active-low reset
//   irq_in        : asynchronous rising-edge request lines
//   address, data_in, data_out, nrd, nwr : core bus slave interface
//   in_interrupt  : core "servicing interrupt" flag
//   interrupt     : vector to the core, 0 = no request
// Build option: define INTC_LEVEL_EN to enable the MODE register.
module tiny16_intc
    import tiny16_intc_pkg::*;
#(
    parameter int          SOURCES        = 8,
    parameter int          INTERRUPT_BITS = 4,
    parameter logic [15:0] BASE_ADDRESS   = 16'hFFF0
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic [SOURCES-1:0]        irq_in,
    input  logic [15:0]               address,
    input  logic [15:0]               data_in,
    output logic [15:0]               data_out,
    input  logic                      nrd,
    input  logic                      nwr,
    input  logic                      in_interrupt,
    output logic [INTERRUPT_BITS-1:0] interrupt
);

    logic [SYNC_DEPTH-1:0][SOURCES-1:0] sync_q;
    logic [SOURCES-1:0]                 prev_q;
    logic [SOURCES-1:0]                 pending_q, pending_d;
    logic [SOURCES-1:0]                 enable_q, enable_d;
    logic [INTERRUPT_BITS-1:0]          active_q, active_d;
    logic                               inInterrupt_q;

    logic                               sel;
    logic                               wrEn;
    regOffset_e                         offset;
    logic [SOURCES-1:0]                 syncOut;
    logic [SOURCES-1:0]                 edgeDet;
    logic [SOURCES-1:0]                 w1cMask;
    logic [SOURCES-1:0]                 ackMask;
    logic [SOURCES-1:0]                 clrMask;
    logic                               unusedData;

    assign sel        = (address[15:2] == BASE_ADDRESS[15:2]);
    assign wrEn       = sel & ~nwr;
    assign offset     = regOffset_e'(address[1:0]);
    assign syncOut    = sync_q[SYNC_DEPTH-1];
    assign edgeDet    = syncOut & ~prev_q;
    assign unusedData = ^data_in[15:SOURCES];

    // Synchroniser chain plus the "previous" flop used for edge detection.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], irq_in};
            prev_q <= syncOut;
        end
    end

    // Acknowledge clears the bit the core took; active_q still holds the
    // vector sampled on the last clock before in_interrupt rose.
    always_comb begin
        ackMask = '0;
        if (in_interrupt && !inInterrupt_q && (active_q != '0)) begin
            ackMask = SOURCES'(1) << (active_q - INTERRUPT_BITS'(1));
        end
    end

    assign w1cMask = (wrEn && (offset == REG_PENDING)) ? data_in[SOURCES-1:0] : '0;
    assign clrMask = w1cMask | ackMask;

`ifdef INTC_LEVEL_EN
    logic [SOURCES-1:0] mode_q, mode_d;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            mode_q <= '0;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (wrEn && (offset == REG_MODE)) begin
            mode_d = data_in[SOURCES-1:0];
        end
    end

    // Level-sensitive bits simply follow the synchronised line, so clears
    // on them are overridden on the very next clock.
    assign pending_d = (mode_q & syncOut)
                     | (~mode_q & ((pending_q & ~clrMask) | edgeDet));
`else
    // An edge arriving with a clear on the same clock keeps the bit set.
    assign pending_d = (pending_q & ~clrMask) | edgeDet;
`endif

    always_comb begin
        enable_d = enable_q;
        if (wrEn && (offset == REG_ENABLE)) begin
            enable_d = data_in[SOURCES-1:0];
        end
    end

    // ACTIVE freezes while the core is servicing so it names the ISR in use.
    assign active_d = in_interrupt ? active_q : interrupt;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            pending_q     <= '0;
            enable_q      <= '0;
            active_q      <= '0;
            inInterrupt_q <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            enable_q      <= enable_d;
            active_q      <= active_d;
            inInterrupt_q <= in_interrupt;
        end
    end

    tiny16_intc_prio #(
        .SOURCES        (SOURCES),
        .INTERRUPT_BITS (INTERRUPT_BITS)
    ) prio (
        .request_i (pending_q & enable_q),
        .vector_o  (interrupt)
    );

    // Zero-latency read mux; the bus is 0 whenever this block is not read.
    always_comb begin
        data_out = '0;
        if (sel && !nrd) begin
            case (offset)
                REG_PENDING: data_out = {{(DATA_WIDTH - SOURCES){1'b0}}, pending_q};
                REG_ENABLE:  data_out = {{(DATA_WIDTH - SOURCES){1'b0}}, enable_q};
                REG_ACTIVE:  data_out = {{(DATA_WIDTH - INTERRUPT_BITS){1'b0}}, active_q};
`ifdef INTC_LEVEL_EN
                REG_MODE:    data_out = {{(DATA_WIDTH - SOURCES){1'b0}}, mode_q};
`else
                REG_MODE:    data_out = '0;
`endif
                default:     data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_tiny16_intc.sv
// tb_tiny16_intc
// Directed testbench for tiny16_intc with hand-computed expected values.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// Build option: define INTC_LEVEL_EN to exercise the MODE register.
module tb_tiny16_intc;

    localparam logic [15:0] BASE = 16'hFFF0;

    logic        clk = 1'b0;
    logic        nreset;
    logic [7:0]  irq_in;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        nrd;
    logic        nwr;
    logic        in_interrupt;
    logic [3:0]  interrupt;

    int checkCount = 0;
    int failCount  = 0;
    logic [15:0] rdVal;

    always #5 clk = ~clk;

    tiny16_intc #(
        .SOURCES        (8),
        .INTERRUPT_BITS (4),
        .BASE_ADDRESS   (BASE)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .irq_in       (irq_in),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .nrd          (nrd),
        .nwr          (nwr),
        .in_interrupt (in_interrupt),
        .interrupt    (interrupt)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // One rising edge, returning on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Holds irqVal for holdCycles edges, then low for two more edges so a
    // one-cycle pulse has reached PENDING when this returns.
    task automatic applyStimulus(input logic [7:0] irqVal, input int holdCycles);
        irq_in = irqVal;
        repeat (holdCycles) tick();
        irq_in = '0;
        tick();
        tick();
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [15:0] val);
        address = addr;
        data_in = val;
        nwr     = 1'b0;
        tick();
        nwr     = 1'b1;
        address = '0;
        data_in = '0;
    endtask

    task automatic busRead(input logic [15:0] addr, output logic [15:0] val);
        address = addr;
        nrd     = 1'b0;
        #1;
        val     = data_out;
        nrd     = 1'b1;
        address = '0;
    endtask

    task automatic checkIrq(input string tag, input logic [3:0] expected);
        #1;
        checkOutput(tag, {12'h000, interrupt}, {12'h000, expected});
    endtask

    initial begin
        irq_in       = '0;
        address      = '0;
        data_in      = '0;
        nrd          = 1'b1;
        nwr          = 1'b1;
        in_interrupt = 1'b0;
        nreset       = 1'b0;
        tick();
        tick();

        $display("[TB] reset state");
        checkIrq("reset_interrupt", 4'd0);
        #1 checkOutput("reset_data_out_idle", data_out, 16'h0000);
        busRead(BASE + 16'd0, rdVal); checkOutput("reset_pending", rdVal, 16'h0000);
        nreset = 1'b1;
        busRead(BASE + 16'd1, rdVal); checkOutput("reset_enable", rdVal, 16'h0000);
        busRead(BASE + 16'd2, rdVal); checkOutput("reset_active", rdVal, 16'h0000);

        $display("[TB] pending while disabled");
        applyStimulus(8'h04, 1);
        busRead(BASE + 16'd0, rdVal); checkOutput("pend_bit2", rdVal, 16'h0004);
        checkIrq("masked_irq", 4'd0);
        busWrite(BASE + 16'd1, 16'h0004);
        checkIrq("enable_bit2_irq", 4'd3);
        busRead(BASE + 16'd1, rdVal); checkOutput("enable_readback", rdVal, 16'h0004);
        busWrite(BASE + 16'd0, 16'h0004);
        busRead(BASE + 16'd0, rdVal); checkOutput("w1c_clear", rdVal, 16'h0000);
        checkIrq("w1c_irq_gone", 4'd0);

        $display("[TB] edge and acknowledge");
        busWrite(BASE + 16'd1, 16'h00FF);
        applyStimulus(8'h20, 1);
        checkIrq("bit5_irq", 4'd6);
        tick();
        busRead(BASE + 16'd2, rdVal); checkOutput("active_6", rdVal, 16'h0006);
        in_interrupt = 1'b1;
        busRead(BASE + 16'd0, rdVal); checkOutput("pend_before_ack", rdVal, 16'h0020);
        tick();
        busRead(BASE + 16'd0, rdVal); checkOutput("pend_after_ack", rdVal, 16'h0000);
        checkIrq("irq_after_ack", 4'd0);
        busRead(BASE + 16'd2, rdVal); checkOutput("active_held", rdVal, 16'h0006);
        in_interrupt = 1'b0;
        tick();

        $display("[TB] priority");
        applyStimulus(8'h42, 1);
        checkIrq("prio_low_wins", 4'd2);
        tick();
        in_interrupt = 1'b1;
        tick();
        checkIrq("prio_next", 4'd7);
        busRead(BASE + 16'd0, rdVal); checkOutput("prio_pend", rdVal, 16'h0040);
        busRead(BASE + 16'd2, rdVal); checkOutput("prio_active", rdVal, 16'h0002);
        in_interrupt = 1'b0;
        tick();
        busRead(BASE + 16'd2, rdVal); checkOutput("prio_active7", rdVal, 16'h0007);
        in_interrupt = 1'b1;
        tick();
        checkIrq("prio_all_acked", 4'd0);
        in_interrupt = 1'b0;
        tick();

        $display("[TB] clear colliding with new edge");
        applyStimulus(8'h08, 1);
        busRead(BASE + 16'd0, rdVal); checkOutput("coll_pend_pre", rdVal, 16'h0008);
        irq_in = 8'h08;
        tick();
        irq_in = '0;
        tick();
        busWrite(BASE + 16'd0, 16'h0008);
        busRead(BASE + 16'd0, rdVal); checkOutput("coll_set_wins", rdVal, 16'h0008);
        checkIrq("coll_irq", 4'd4);
        busWrite(BASE + 16'd0, 16'h0008);
        busRead(BASE + 16'd0, rdVal); checkOutput("coll_cleared", rdVal, 16'h0000);

        $display("[TB] bus decode");
        busWrite(BASE + 16'd1, 16'hFFFF);
        busRead(BASE + 16'd1, rdVal); checkOutput("enable_upper_zero", rdVal, 16'h00FF);
        applyStimulus(8'h01, 1);
        busRead(BASE + 16'd4, rdVal); checkOutput("unsel_base4", rdVal, 16'h0000);
        busRead(BASE + 16'd5, rdVal); checkOutput("unsel_base5", rdVal, 16'h0000);
        address = BASE;
        #1 checkOutput("nrd_high", data_out, 16'h0000);
        address = BASE + 16'd1;
        data_in = 16'h0001;
        tick();
        address = '0;
        busRead(BASE + 16'd1, rdVal); checkOutput("nwr_high_nochange", rdVal, 16'h00FF);
        busWrite(BASE + 16'd5, 16'h0001);
        busRead(BASE + 16'd1, rdVal); checkOutput("unsel_write", rdVal, 16'h00FF);
        busWrite(BASE + 16'd2, 16'h0005);
        busRead(BASE + 16'd2, rdVal); checkOutput("active_ro", rdVal, 16'h0001);
        busWrite(BASE + 16'd0, 16'h0001);

        $display("[TB] disable keeps pending");
        applyStimulus(8'h80, 1);
        checkIrq("bit7_irq", 4'd8);
        busWrite(BASE + 16'd1, 16'h0000);
        checkIrq("disabled_irq", 4'd0);
        busRead(BASE + 16'd0, rdVal); checkOutput("disabled_pend", rdVal, 16'h0080);
        busWrite(BASE + 16'd1, 16'h0080);
        checkIrq("reenabled_irq", 4'd8);

        $display("[TB] reset mid-operation");
        applyStimulus(8'h02, 1);
        irq_in  = 8'h10;
        address = BASE + 16'd1;
        data_in = 16'h000F;
        nwr     = 1'b0;
        nreset  = 1'b0;
        tick();
        nwr     = 1'b1;
        address = '0;
        data_in = '0;
        tick();
        nreset  = 1'b1;
        busRead(BASE + 16'd1, rdVal); checkOutput("midreset_enable", rdVal, 16'h0000);
        busRead(BASE + 16'd0, rdVal); checkOutput("midreset_pend", rdVal, 16'h0000);
        tick();
        tick();
        busRead(BASE + 16'd0, rdVal); checkOutput("startup_2clk", rdVal, 16'h0000);
        tick();
        busRead(BASE + 16'd0, rdVal); checkOutput("startup_3clk", rdVal, 16'h0010);
        irq_in = '0;
        busWrite(BASE + 16'd0, 16'h0010);

`ifdef INTC_LEVEL_EN
        $display("[TB] level mode");
        busWrite(BASE + 16'd3, 16'h0001);
        busRead(BASE + 16'd3, rdVal); checkOutput("mode_readback", rdVal, 16'h0001);
        busWrite(BASE + 16'd1, 16'h0001);
        irq_in = 8'h01;
        tick();
        tick();
        tick();
        checkIrq("level_irq", 4'd1);
        tick();
        in_interrupt = 1'b1;
        tick();
        checkIrq("level_after_ack", 4'd1);
        busWrite(BASE + 16'd0, 16'h0001);
        checkIrq("level_after_w1c", 4'd1);
        in_interrupt = 1'b0;
        irq_in = '0;
        tick();
        tick();
        checkIrq("level_drop_2clk", 4'd1);
        tick();
        checkIrq("level_drop_3clk", 4'd0);
        busWrite(BASE + 16'd3, 16'h0000);
`else
        $display("[TB] mode register absent");
        busWrite(BASE + 16'd3, 16'hFFFF);
        busRead(BASE + 16'd3, rdVal); checkOutput("mode_reads_zero", rdVal, 16'h0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
